// File: rtl/diamond_field.sv
// Collectible-diamond manager for one colour of diamond: eaten flags, collected count,
// shared vertical bob animation and the per-pixel hit/ROM-address path for the colour mapper.
module diamond_field #(
  parameter int unsigned         NUM_D   = 4,
  parameter int unsigned         SPR_W   = 20,
  parameter int unsigned         SPR_H   = 20,
  parameter int unsigned         ADDR_W  = 9,
  parameter logic [NUM_D*10-1:0] D_X     = {10'd458, 10'd300, 10'd150, 10'd40},
  parameter logic [NUM_D*10-1:0] D_Y     = {10'd408, 10'd300, 10'd200, 10'd100},
  parameter int unsigned         BOB_A   = 3,
  parameter int unsigned         BOB_DIV = 4
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_clk,
  input  logic                         level_restart,
  input  logic [9:0]                   player_x,
  input  logic [9:0]                   player_y,
  input  logic [5:0]                   player_w,
  input  logic [5:0]                   player_h,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  output logic                         is_diamond,
  output logic [ADDR_W-1:0]            diamond_address,
  output logic [NUM_D-1:0]             diamond_eaten,
  output logic [$clog2(NUM_D+1)-1:0]   collected,
  output logic                         all_collected,
  output logic                         eat_pulse
);

  localparam int unsigned CNT_W = $clog2(NUM_D + 1);
  localparam int unsigned DIV_W = (BOB_DIV > 1) ? $clog2(BOB_DIV) : 1;
  localparam logic [10:0] SW    = 11'(SPR_W);
  localparam logic [10:0] SH    = 11'(SPR_H);

  logic [2:0]       sync;
  logic             tick;
  logic [9:0]       phase;
  logic [9:0]       offset;
  logic [DIV_W-1:0] div_cnt;
  logic [10:0]      x_l [NUM_D];
  logic [10:0]      y_t [NUM_D];
  logic [NUM_D-1:0] new_eat;
  logic [CNT_W-1:0] pop;
  logic [CNT_W-1:0] coll_next;
  logic [10:0]      px, pxe, py, pye, dxp, dyp;

  // sync[2] only remembers the previous synchronised level for edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sync <= '0;
    else          sync <= {sync[1:0], frame_clk};
  end

  assign tick   = sync[1] & ~sync[2];
  assign offset = (phase <= 10'(BOB_A)) ? phase : 10'(2 * BOB_A) - phase;

  assign px  = {1'b0, player_x};
  assign py  = {1'b0, player_y};
  assign pxe = {1'b0, player_x} + {5'b0, player_w};
  assign pye = {1'b0, player_y} + {5'b0, player_h};
  assign dxp = {1'b0, DrawX};
  assign dyp = {1'b0, DrawY};

  always_comb begin
    for (int unsigned i = 0; i < NUM_D; i++) begin
      x_l[i] = {1'b0, D_X[i*10 +: 10]};
      y_t[i] = {1'b0, D_Y[i*10 +: 10]} - {1'b0, offset};
    end
  end

  always_comb begin
    new_eat = '0;
    pop     = '0;
    for (int unsigned i = 0; i < NUM_D; i++) begin
      if (tick && !diamond_eaten[i] &&
          px < x_l[i] + SW && pxe > x_l[i] &&
          py < y_t[i] + SH && pye > y_t[i]) begin
        new_eat[i] = 1'b1;
      end
      pop = pop + CNT_W'(new_eat[i]);
    end
    coll_next = collected + pop;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      diamond_eaten <= '0;
      collected     <= '0;
      all_collected <= 1'b0;
      eat_pulse     <= 1'b0;
      phase         <= '0;
      div_cnt       <= '0;
    end else if (level_restart) begin
      diamond_eaten <= '0;
      collected     <= '0;
      all_collected <= 1'b0;
      eat_pulse     <= 1'b0;
      phase         <= '0;
      div_cnt       <= '0;
    end else begin
      diamond_eaten <= diamond_eaten | new_eat;
      collected     <= coll_next;
      all_collected <= (coll_next == CNT_W'(NUM_D));
      eat_pulse     <= (pop != '0);
      if (tick) begin
        if (div_cnt == DIV_W'(BOB_DIV - 1)) begin
          div_cnt <= '0;
          phase   <= (BOB_A == 0 || phase == 10'(2 * BOB_A - 1)) ? '0 : phase + 10'd1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  // Ascending scan with a first-hit guard gives the lowest index priority
  always_comb begin
    is_diamond      = 1'b0;
    diamond_address = '0;
    for (int unsigned i = 0; i < NUM_D; i++) begin
      if (!is_diamond && !diamond_eaten[i] &&
          dxp >= x_l[i] && dxp < x_l[i] + SW &&
          dyp >= y_t[i] && dyp < y_t[i] + SH) begin
        is_diamond      = 1'b1;
        diamond_address = ADDR_W'(32'(dxp - x_l[i]) + 32'(dyp - y_t[i]) * SPR_W);
      end
    end
  end

endmodule

// File: tb/tb_diamond_field.sv
// Directed bench for diamond_field: a non-bobbing instance with the default layout and a
// bobbing instance with two overlapping diamonds.
module tb_diamond_field;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       level_restart = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [9:0] p0_x, p0_y, p1_x, p1_y;
  logic [5:0] p0_w, p0_h, p1_w, p1_h;

  logic       is0, is1;
  logic [8:0] addr0, addr1;
  logic [3:0] eaten0, eaten1;
  logic [2:0] coll0, coll1;
  logic       all0, all1, pulse0, pulse1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_off [11] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
  int xs [3] = '{40, 150, 300};
  int ys [3] = '{100, 200, 300};

  diamond_field #(.BOB_A(0)) u0 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .level_restart(level_restart),
    .player_x(p0_x), .player_y(p0_y), .player_w(p0_w), .player_h(p0_h),
    .DrawX(DrawX), .DrawY(DrawY),
    .is_diamond(is0), .diamond_address(addr0), .diamond_eaten(eaten0),
    .collected(coll0), .all_collected(all0), .eat_pulse(pulse0)
  );

  diamond_field #(
    .D_X({10'd458, 10'd300, 10'd160, 10'd150}),
    .D_Y({10'd408, 10'd300, 10'd210, 10'd200}),
    .BOB_A(3),
    .BOB_DIV(4)
  ) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .level_restart(level_restart),
    .player_x(p1_x), .player_y(p1_y), .player_w(p1_w), .player_h(p1_h),
    .DrawX(DrawX), .DrawY(DrawY),
    .is_diamond(is1), .diamond_address(addr1), .diamond_eaten(eaten1),
    .collected(coll1), .all_collected(all1), .eat_pulse(pulse1)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic park0();
    p0_x = '0; p0_y = '0; p0_w = 6'd1; p0_h = 6'd1;
  endtask

  task automatic park1();
    p1_x = '0; p1_y = '0; p1_w = 6'd1; p1_h = 6'd1;
  endtask

  // Returns at the falling edge just after the edge on which the tick takes effect
  task automatic frame_edge();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic frame_release();
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    park0();
    park1();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_eaten", 32'(eaten0), 0);
    check("rst_coll",  32'(coll0),  0);
    check("rst_all",   32'(all0),   0);
    check("rst_pulse", 32'(pulse0), 0);
    Reset_n = 1'b1;

    DrawX = 10'd458; DrawY = 10'd408; #1;
    check("pix_tl_is",   32'(is0),   1);
    check("pix_tl_addr", 32'(addr0), 0);
    DrawX = 10'd477; DrawY = 10'd427; #1;
    check("pix_br_is",   32'(is0),   1);
    check("pix_br_addr", 32'(addr0), 399);
    DrawX = 10'd478; #1;
    check("pix_out_is",   32'(is0),   0);
    check("pix_out_addr", 32'(addr0), 0);
    DrawX = 10'd165; DrawY = 10'd215; #1;
    check("prio_is",   32'(is1),   1);
    check("prio_addr", 32'(addr1), 315);

    // single eat with latency and pulse-width checks
    p0_x = 10'd465; p0_y = 10'd410; p0_w = 6'd10; p0_h = 6'd10;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("eat3_early", 32'(eaten0), 0);
    @(negedge Clk);
    check("eat3_eaten", 32'(eaten0), 8);
    check("eat3_coll",  32'(coll0),  1);
    check("eat3_pulse", 32'(pulse0), 1);
    check("eat3_all",   32'(all0),   0);
    @(negedge Clk);
    check("eat3_pulse_end", 32'(pulse0), 0);
    check("eat3_coll_hold", 32'(coll0),  1);
    DrawX = 10'd460; DrawY = 10'd410; #1;
    check("eat3_pix_is",   32'(is0),   0);
    check("eat3_pix_addr", 32'(addr0), 0);
    frame_release();

    // double eat on u1; u0 player still on an eaten diamond
    p1_x = 10'd150; p1_y = 10'd200; p1_w = 6'd40; p1_h = 6'd40;
    frame_edge();
    check("dbl_eaten",   32'(eaten1), 3);
    check("dbl_coll",    32'(coll1),  2);
    check("dbl_pulse",   32'(pulse1), 1);
    check("retrig_coll", 32'(coll0),  1);
    check("retrig_pulse",32'(pulse0), 0);
    @(negedge Clk);
    check("dbl_pulse_end", 32'(pulse1), 0);
    check("dbl_coll_hold", 32'(coll1),  2);
    frame_release();
    park0();

    // touching edge is not a hit; one pixel of overlap is
    p1_x = 10'd478; p1_y = 10'd400; p1_w = 6'd10; p1_h = 6'd30;
    frame_edge();
    check("edge_touch_eaten", 32'(eaten1), 3);
    check("edge_touch_pulse", 32'(pulse1), 0);
    frame_release();
    p1_x = 10'd477;
    frame_edge();
    check("edge_hit_eaten", 32'(eaten1), 11);
    check("edge_hit_coll",  32'(coll1),  3);
    check("edge_hit_pulse", 32'(pulse1), 1);
    frame_release();
    park1();

    for (int i = 0; i < 3; i++) begin
      p0_x = 10'(xs[i]); p0_y = 10'(ys[i]); p0_w = 6'd10; p0_h = 6'd10;
      frame_edge();
      check("all_coll", 32'(coll0), 32'(i + 2));
      check("all_flag", 32'(all0),  (i == 2) ? 1 : 0);
      frame_release();
    end
    check("all_eaten", 32'(eaten0), 15);

    // restart coincident with a tick while overlapping diamond 0
    p0_x = 10'd40; p0_y = 10'd100; p0_w = 6'd10; p0_h = 6'd10;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk) level_restart = 1'b1;
    @(negedge Clk) level_restart = 1'b0;
    check("rs_eaten", 32'(eaten0), 0);
    check("rs_coll",  32'(coll0),  0);
    check("rs_all",   32'(all0),   0);
    check("rs_pulse", 32'(pulse0), 0);
    frame_release();
    frame_edge();
    check("rs_reeat_eaten", 32'(eaten0), 1);
    check("rs_reeat_coll",  32'(coll0),  1);
    frame_release();
    park0();

    // asynchronous reset between clock edges
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_eaten", 32'(eaten0), 0);
    check("arst_coll",  32'(coll0),  0);
    check("arst_all",   32'(all0),   0);
    check("arst_pulse", 32'(pulse0), 0);
    @(negedge Clk) Reset_n = 1'b1;

    // bob sequence observed through the row offset of diamond 3 at its base top row
    DrawX = 10'd458; DrawY = 10'd408; #1;
    check("bob_addr0", 32'(addr1), 0);
    for (int k = 1; k <= 40; k++) begin
      frame_edge();
      check("bob_is",   32'(is1),   1);
      check("bob_addr", 32'(addr1), 32'(exp_off[k / 4] * 20));
      if (k == 12) begin
        DrawY = 10'd405; #1;
        check("bob_top_is",   32'(is1),   1);
        check("bob_top_addr", 32'(addr1), 0);
        DrawY = 10'd404; #1;
        check("bob_above_is", 32'(is1), 0);
        DrawY = 10'd408;
      end
      frame_release();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
